// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, the width
// of the sequence counter and its saturating increment.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int COUNT_WIDTH = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Both flops clear on the synchronous reset so the synchronized level reads
// low until the input has been sampled twice after reset.
module reset_sequencer_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous level through two flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all channel resets low until the PLL is locked,
// keeps them low for 2^HOLD_WIDTH cycles, then releases them one at a time
// STAGGER cycles apart (bit 0 first). A button request, loss of lock or the
// optional periodic timer restarts the sequence.
//
// Build option: define RESET_SEQ_DEBOUNCE_EN to require the synchronized
// request to be stable high for 2^DEBOUNCE_WIDTH cycles before it acts.
// Without the macro the synchronized request acts directly.
//
// The FSM state is held in the internal signal 'state' (seq_state_t) so
// checkers can bind to it without extra ports.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int CHANNELS       = 3,
  parameter int HOLD_WIDTH     = 25,
  parameter int STAGGER        = 16,
  parameter int PERIODIC       = 0,
  parameter int PERIOD_WIDTH   = 26,
  parameter int DEBOUNCE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   lock,
  input  logic                   req,
  output logic [CHANNELS-1:0]    n_reset_out,
  output logic                   ready,
  output logic [COUNT_WIDTH-1:0] reset_count
);

  // Reject configurations the release logic cannot represent.
  if (CHANNELS < 1 || CHANNELS > 8 || STAGGER < 1 || HOLD_WIDTH < 1 ||
      PERIOD_WIDTH < 1 || DEBOUNCE_WIDTH < 1) begin : g_bad_params
    $error("reset_sequencer: parameter out of range");
  end

  localparam logic [CHANNELS-1:0] BIT0 = CHANNELS'(1);
  // A single-cycle stagger still needs a one-bit counter that stays at zero.
  localparam int                  STAG_W    = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam logic [STAG_W-1:0]   STAG_LAST = STAG_W'(STAGGER - 1);

  seq_state_t              state;
  logic                    lock_s;
  logic                    req_s;
  logic                    eff_req;
  logic [HOLD_WIDTH-1:0]   hold_cnt;
  logic [STAG_W-1:0]       stag_cnt;
  logic [PERIOD_WIDTH-1:0] period_cnt;
  logic [CHANNELS-1:0]     next_bits;
  logic                    period_wrap;
  logic                    start_hold;

  reset_sequencer_sync2 u_sync_lock (
    .clk   (clk),
    .reset (reset),
    .d     (lock),
    .q     (lock_s)
  );

  reset_sequencer_sync2 u_sync_req (
    .clk   (clk),
    .reset (reset),
    .d     (req),
    .q     (req_s)
  );

`ifdef RESET_SEQ_DEBOUNCE_EN
  // Top bit set means 2^DEBOUNCE_WIDTH consecutive high samples were seen.
  logic [DEBOUNCE_WIDTH:0] deb_cnt;

  // Count consecutive high request samples; any low sample starts over.
  always_ff @(posedge clk) begin
    if (reset || !req_s) begin
      deb_cnt <= '0;
    end else if (!deb_cnt[DEBOUNCE_WIDTH]) begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign eff_req = deb_cnt[DEBOUNCE_WIDTH];
`else
  assign eff_req = req_s;
`endif

  // Resets released so far, plus the next channel in line.
  assign next_bits = (n_reset_out << 1) | BIT0;

  // Periodic re-reset fires when the RUN-time counter is about to wrap.
  assign period_wrap = (PERIODIC != 0) && (&period_cnt);

  // Every way into HOLD funnels through this one term, so a request that
  // coincides with a periodic wrap still produces a single entry.
  assign start_hold = (state == WAIT_LOCK) ||
                      (((state == RELEASE) || (state == RUN)) && eff_req) ||
                      ((state == RUN) && period_wrap);

  // Sequencer FSM with registered resets, ready flag and sequence counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_LOCK;
      n_reset_out <= '0;
      ready       <= 1'b0;
      reset_count <= '0;
      hold_cnt    <= '0;
      stag_cnt    <= '0;
      period_cnt  <= '0;
    end else if (!lock_s) begin
      // Loss of lock overrides everything and drops all channels at once.
      state       <= WAIT_LOCK;
      n_reset_out <= '0;
      ready       <= 1'b0;
      hold_cnt    <= '0;
      stag_cnt    <= '0;
      period_cnt  <= '0;
    end else if (start_hold) begin
      state       <= HOLD;
      n_reset_out <= '0;
      ready       <= 1'b0;
      hold_cnt    <= '0;
      stag_cnt    <= '0;
      reset_count <= sat_inc(reset_count);
    end else begin
      case (state)
        HOLD: begin
          if (eff_req) begin
            // A held request keeps the hold period from expiring.
            hold_cnt <= '0;
          end else if (&hold_cnt) begin
            n_reset_out <= BIT0;
            hold_cnt    <= '0;
            stag_cnt    <= '0;
            if (&BIT0) begin
              state      <= RUN;
              ready      <= 1'b1;
              period_cnt <= '0;
            end else begin
              state <= RELEASE;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (stag_cnt == STAG_LAST) begin
            n_reset_out <= next_bits;
            stag_cnt    <= '0;
            if (&next_bits) begin
              state      <= RUN;
              ready      <= 1'b1;
              period_cnt <= '0;
            end
          end else begin
            stag_cnt <= stag_cnt + 1'b1;
          end
        end
        RUN: begin
          period_cnt <= period_cnt + 1'b1;
        end
        WAIT_LOCK: begin
          // Left through start_hold as soon as lock is seen.
        end
        default: begin
          state <= WAIT_LOCK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with CHANNELS=3, HOLD_WIDTH=3,
// STAGGER=4, PERIODIC=1, PERIOD_WIDTH=6, DEBOUNCE_WIDTH=2.
// Edges are numbered from the first posedge after reset is released; every
// expected value below is tied to an absolute edge number.
// With RESET_SEQ_DEBOUNCE_EN defined, a separate debounce flow runs instead.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  logic       clk;
  logic       reset;
  logic       lock;
  logic       req;
  logic [2:0] n_reset_out;
  logic       ready;
  logic [7:0] reset_count;

  int vectors;
  int miscompares;
  int edge_n;

  reset_sequencer #(
    .CHANNELS       (3),
    .HOLD_WIDTH     (3),
    .STAGGER        (4),
    .PERIODIC       (1),
    .PERIOD_WIDTH   (6),
    .DEBOUNCE_WIDTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lock        (lock),
    .req         (req),
    .n_reset_out (n_reset_out),
    .ready       (ready),
    .reset_count (reset_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: advance one edge and settle, or run to an absolute edge.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  // Scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] exp_bits,
                            input logic exp_ready, input logic [7:0] exp_count);
    check_eq({tag, ".bits"},  32'(n_reset_out), 32'(exp_bits));
    check_eq({tag, ".ready"}, 32'(ready),       32'(exp_ready));
    check_eq({tag, ".count"}, 32'(reset_count), 32'(exp_count));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    edge_n      = 0;
    reset       = 1'b1;
    lock        = 1'b1;
    req         = 1'b0;
    repeat (3) tick();
    check_outs("reset", 3'b000, 1'b0, 8'd0);
    reset  = 1'b0;
    edge_n = 0;

`ifdef RESET_SEQ_DEBOUNCE_EN
    // Same power-up sequence: HOLD at 3, bit0 at 11, RUN at 19.
    run_to(19);  check_outs("db_run",     3'b111, 1'b1, 8'd1);
    // Request high for 3 samples never fills the 4-cycle window.
    run_to(20);  req = 1'b1;
    run_to(23);  req = 1'b0;
    run_to(30);  check_outs("db_short",   3'b111, 1'b1, 8'd1);
    // Request high for 10 samples: debounced at edge 46, HOLD at 47.
    run_to(40);  req = 1'b1;
    run_to(46);  check_outs("db_pre",     3'b111, 1'b1, 8'd1);
    run_to(47);  check_outs("db_hold",    3'b000, 1'b0, 8'd2);
    run_to(50);  req = 1'b0;
    // Held request reclears the hold counter through edge 53: bit0 at 61.
    run_to(60);  check_outs("db_held",    3'b000, 1'b0, 8'd2);
    run_to(61);  check_outs("db_bit0",    3'b001, 1'b0, 8'd2);
`else
    // Lock seen synchronized at edge 3: HOLD, bit0 at 11, bit1 15, bit2 19.
    run_to(3);   check_outs("hold_entry", 3'b000, 1'b0, 8'd1);
    run_to(10);  check_outs("hold_end",   3'b000, 1'b0, 8'd1);
    run_to(11);  check_outs("bit0",       3'b001, 1'b0, 8'd1);
    run_to(14);  check_outs("bit0_only",  3'b001, 1'b0, 8'd1);
    run_to(15);  check_outs("bit1",       3'b011, 1'b0, 8'd1);
    run_to(19);  check_outs("bit2_run",   3'b111, 1'b1, 8'd1);

    // One-cycle request rising before edge 21: all low after edge 23.
    run_to(20);  req = 1'b1;
    run_to(21);  req = 1'b0;
    run_to(22);  check_outs("req_lat",    3'b111, 1'b1, 8'd1);
    run_to(23);  check_outs("req_hold",   3'b000, 1'b0, 8'd2);
    run_to(31);  check_outs("req_bit0",   3'b001, 1'b0, 8'd2);
    run_to(39);  check_outs("req_run",    3'b111, 1'b1, 8'd2);

    // Lock low for 5 samples (edges 41..45): WAIT_LOCK at 43, HOLD at 48.
    run_to(40);  lock = 1'b0;
    run_to(42);  check_outs("lock_lat",   3'b111, 1'b1, 8'd2);
    run_to(43);  check_outs("lock_lost",  3'b000, 1'b0, 8'd2);
    run_to(45);  lock = 1'b1;
    run_to(47);  check_outs("lock_wait",  3'b000, 1'b0, 8'd2);
    run_to(48);  check_outs("lock_hold",  3'b000, 1'b0, 8'd3);
    run_to(56);  check_outs("lock_bit0",  3'b001, 1'b0, 8'd3);
    run_to(64);  check_outs("lock_run",   3'b111, 1'b1, 8'd3);

    // RUN from 64: periodic wrap at 128, then one entry every 80 edges.
    run_to(127); check_outs("per_pre",    3'b111, 1'b1, 8'd3);
    run_to(128); check_outs("per_hold",   3'b000, 1'b0, 8'd4);

    // Request arrives on the same edge as the wrap at 208: one entry only.
    run_to(205); req = 1'b1;
    run_to(206); req = 1'b0;
    run_to(207); check_outs("both_pre",   3'b111, 1'b1, 8'd4);
    run_to(208); check_outs("both_hold",  3'b000, 1'b0, 8'd5);
    run_to(209); check_outs("both_once",  3'b000, 1'b0, 8'd5);

    // Entry n lands on edge 128 + (n-4)*80.
    run_to(20207); check_outs("sat_254",  3'b111, 1'b1, 8'd254);
    run_to(20208); check_outs("sat_255",  3'b000, 1'b0, 8'd255);
    run_to(23807); check_outs("sat_299",  3'b111, 1'b1, 8'd255);
    run_to(23808); check_outs("sat_300",  3'b000, 1'b0, 8'd255);

    // Reset while only bit0 is released aborts the sequence on the next edge.
    run_to(23817); check_outs("mid_rel", 3'b001, 1'b0, 8'd255);
    reset = 1'b1;
    run_to(23818); check_outs("abort",   3'b000, 1'b0, 8'd0);
    reset = 1'b0;
`endif

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
